// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
// alarm_pkg : shared types, codes, field limits and CT slices for the alarm
//             set controller.   Rev 1.0
// ============================================================================
package alarm_pkg;

    localparam logic [1:0] S_RUN        = 2'b00;
    localparam logic [1:0] S_SET_TIME   = 2'b01;
    localparam logic [1:0] S_SHOW_ALARM = 2'b10;
    localparam logic [1:0] S_SET_ALARM  = 2'b11;

    typedef enum logic [1:0] {
        STATE_RUN        = S_RUN,
        STATE_SET_TIME   = S_SET_TIME,
        STATE_SHOW_ALARM = S_SHOW_ALARM,
        STATE_SET_ALARM  = S_SET_ALARM
    } state_e;

    typedef enum logic [2:0] {
        FLD_DAY  = 3'd0,
        FLD_HOUR = 3'd1,
        FLD_MT   = 3'd2,
        FLD_MU   = 3'd3,
        FLD_EN   = 3'd4
    } field_e;

    localparam logic [1:0] CW_NONE = 2'b00;
    localparam logic [1:0] CW_MIN  = 2'b01;
    localparam logic [1:0] CW_HOUR = 2'b10;
    localparam logic [1:0] CW_DAY  = 2'b11;

    localparam logic [1:0] CW1_NONE = 2'b00;
    localparam logic [1:0] CW1_MU   = 2'b01;
    localparam logic [1:0] CW1_MT   = 2'b10;
    localparam logic [1:0] CW1_EN   = 2'b11;

    localparam int DAY_MAX  = 6;
    localparam int HOUR_MAX = 23;
    localparam int MT_MAX   = 5;
    localparam int MU_MAX   = 9;

    localparam int DAY_LSB  = 12;
    localparam int DAY_W    = 3;
    localparam int HOUR_LSB = 7;
    localparam int HOUR_W   = 5;
    localparam int MT_LSB   = 4;
    localparam int MT_W     = 3;
    localparam int MU_LSB   = 0;
    localparam int MU_W     = 4;

    // Widest field (hour) sets the width of the shared wrap unit.
    localparam int FIELD_W  = 5;

    function automatic logic [3:0] blink_code(input state_e s, input field_e f);
        logic [3:0] code;
        code = {CW_NONE, CW1_NONE};
        if (s == STATE_SET_TIME || s == STATE_SET_ALARM) begin
            case (f)
                FLD_DAY:  code = {CW_DAY,  CW1_NONE};
                FLD_HOUR: code = {CW_HOUR, CW1_NONE};
                FLD_MT:   code = {CW_MIN,  CW1_MT};
                FLD_MU:   code = {CW_MIN,  CW1_MU};
                FLD_EN:   code = {CW_NONE, CW1_EN};
                default:  code = {CW_NONE, CW1_NONE};
            endcase
        end
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/field_wrap.sv
`default_nettype none
// ============================================================================
// field_wrap : modular increment/decrement of one time field in [0, limit].
//              Rev 1.0
// ============================================================================
module field_wrap
    import alarm_pkg::*;
(
    input  logic [FIELD_W-1:0] value,
    input  logic [FIELD_W-1:0] limit,
    input  logic               up,
    input  logic               down,
    output logic [FIELD_W-1:0] result
);

    always_comb begin
        result = value;
        if (up && !down) begin
            result = (value >= limit) ? '0 : value + FIELD_W'(1);
        end else if (down && !up) begin
            result = (value == '0 || value > limit) ? limit : value - FIELD_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/alarm_set_controller.sv
`default_nettype none
// ============================================================================
// alarm_set_controller : button-driven mode/field editor for time and alarm,
//                        owner of the alarm word and the ring output. Rev 1.0
// ============================================================================
module alarm_set_controller
    import alarm_pkg::*;
#(
    parameter int TIMEOUT_CYC = 2400,
    parameter int RING_CYC    = 7200
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        btn_mode,
    input  logic        btn_next,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic [14:0] CT,
    output logic [1:0]  S,
    output logic [1:0]  CW,
    output logic [1:0]  CW1,
    output logic [15:0] ST,
    output logic [14:0] time_val,
    output logic        time_load,
    output logic        ring
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int RC_W = $clog2(RING_CYC + 1);

    logic [3:0]         btn_q;
    logic [14:0]        ct_q;
    state_e             state_q, state_d;
    field_e             cursor_q, cursor_d;
    logic [14:0]        edit_q, edit_d;
    logic [15:0]        st_q, st_d;
    logic               time_load_q, time_load_d;
    logic               ring_q, ring_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [RC_W-1:0]    ring_cnt_q, ring_cnt_d;
    logic [1:0]         cw_q, cw_d;
    logic [1:0]         cw1_q, cw1_d;

    logic [3:0]         btn_now;
    logic [3:0]         press;
    logic               any_press;
    logic               mode_p, next_p, inc_p, dec_p;
    logic               ring_set;
    logic [14:0]        edit_word;
    logic [14:0]        edited;
    logic [FIELD_W-1:0] fld_val, fld_lim, fld_new;

    assign btn_now   = {btn_mode, btn_next, btn_inc, btn_dec};
    assign press     = btn_now & ~btn_q;
    assign any_press = |press;
    assign mode_p    = press[3];
    assign next_p    = press[2];
    assign inc_p     = press[1];
    assign dec_p     = press[0];

    // A fresh minute match only: CT must have just changed onto the alarm time.
    assign ring_set  = st_q[15] && (CT == st_q[14:0]) && (CT != ct_q) &&
                       (state_q == STATE_RUN || state_q == STATE_SHOW_ALARM);

    always_comb begin
        edit_word = (state_q == STATE_SET_ALARM) ? st_q[14:0] : edit_q;
        fld_val   = '0;
        fld_lim   = '0;
        case (cursor_q)
            FLD_DAY: begin
                fld_val = FIELD_W'(edit_word[DAY_LSB +: DAY_W]);
                fld_lim = FIELD_W'(DAY_MAX);
            end
            FLD_HOUR: begin
                fld_val = FIELD_W'(edit_word[HOUR_LSB +: HOUR_W]);
                fld_lim = FIELD_W'(HOUR_MAX);
            end
            FLD_MT: begin
                fld_val = FIELD_W'(edit_word[MT_LSB +: MT_W]);
                fld_lim = FIELD_W'(MT_MAX);
            end
            FLD_MU: begin
                fld_val = FIELD_W'(edit_word[MU_LSB +: MU_W]);
                fld_lim = FIELD_W'(MU_MAX);
            end
            default: begin
                fld_val = '0;
                fld_lim = '0;
            end
        endcase
    end

    field_wrap u_field_wrap (
        .value  (fld_val),
        .limit  (fld_lim),
        .up     (inc_p & ~dec_p),
        .down   (dec_p & ~inc_p),
        .result (fld_new)
    );

    always_comb begin
        edited = edit_word;
        case (cursor_q)
            FLD_DAY:  edited[DAY_LSB +: DAY_W]   = fld_new[DAY_W-1:0];
            FLD_HOUR: edited[HOUR_LSB +: HOUR_W] = fld_new[HOUR_W-1:0];
            FLD_MT:   edited[MT_LSB +: MT_W]     = fld_new[MT_W-1:0];
            FLD_MU:   edited[MU_LSB +: MU_W]     = fld_new[MU_W-1:0];
            default:  edited = edit_word;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cursor_d    = cursor_q;
        edit_d      = edit_q;
        st_d        = st_q;
        time_load_d = 1'b0;
        ring_d      = ring_q;
        ring_cnt_d  = ring_cnt_q;
        to_cnt_d    = to_cnt_q;

        if (any_press) begin
            to_cnt_d = '0;
            if (ring_q) begin
                // Silencing press is consumed here and does nothing else.
                ring_d     = 1'b0;
                ring_cnt_d = '0;
            end else if (mode_p) begin
                case (state_q)
                    STATE_RUN: begin
                        state_d  = STATE_SET_TIME;
                        cursor_d = FLD_DAY;
                        edit_d   = CT;
                    end
                    STATE_SET_TIME: begin
                        state_d     = STATE_SHOW_ALARM;
                        time_load_d = 1'b1;
                    end
                    STATE_SHOW_ALARM: begin
                        state_d  = STATE_SET_ALARM;
                        cursor_d = FLD_DAY;
                    end
                    default: state_d = STATE_RUN;
                endcase
            end else if (next_p) begin
                if (state_q == STATE_SET_TIME || state_q == STATE_SET_ALARM) begin
                    case (cursor_q)
                        FLD_DAY:  cursor_d = FLD_HOUR;
                        FLD_HOUR: cursor_d = FLD_MT;
                        FLD_MT:   cursor_d = FLD_MU;
                        FLD_MU:   cursor_d = (state_q == STATE_SET_ALARM) ? FLD_EN : FLD_DAY;
                        default:  cursor_d = FLD_DAY;
                    endcase
                end
            end else if (inc_p ^ dec_p) begin
                if (state_q == STATE_SET_TIME) begin
                    edit_d = edited;
                end else if (state_q == STATE_SET_ALARM) begin
                    if (cursor_q == FLD_EN) begin
                        st_d[15] = ~st_q[15];
                    end else begin
                        st_d[14:0] = edited;
                    end
                end
            end
        end else begin
            if (state_q != STATE_RUN) begin
                if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    if (state_q == STATE_SET_TIME) begin
                        edit_d = '0;
                    end
                    state_d  = STATE_RUN;
                    to_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            if (ring_set) begin
                ring_d     = 1'b1;
                ring_cnt_d = '0;
            end else if (ring_q) begin
                if (!st_q[15] || ring_cnt_q == RC_W'(RING_CYC - 1)) begin
                    ring_d     = 1'b0;
                    ring_cnt_d = '0;
                end else begin
                    ring_cnt_d = ring_cnt_q + RC_W'(1);
                end
            end
        end

        {cw_d, cw1_d} = blink_code(state_d, cursor_d);
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            btn_q       <= '0;
            ct_q        <= '0;
            state_q     <= STATE_RUN;
            cursor_q    <= FLD_DAY;
            edit_q      <= '0;
            st_q        <= '0;
            time_load_q <= 1'b0;
            ring_q      <= 1'b0;
            ring_cnt_q  <= '0;
            to_cnt_q    <= '0;
            cw_q        <= CW_NONE;
            cw1_q       <= CW1_NONE;
        end else begin
            btn_q       <= btn_now;
            ct_q        <= CT;
            state_q     <= state_d;
            cursor_q    <= cursor_d;
            edit_q      <= edit_d;
            st_q        <= st_d;
            time_load_q <= time_load_d;
            ring_q      <= ring_d;
            ring_cnt_q  <= ring_cnt_d;
            to_cnt_q    <= to_cnt_d;
            cw_q        <= cw_d;
            cw1_q       <= cw1_d;
        end
    end

    assign S         = state_q;
    assign CW        = cw_q;
    assign CW1       = cw1_q;
    assign ST        = st_q;
    assign time_val  = edit_q;
    assign time_load = time_load_q;
    assign ring      = ring_q;

endmodule
`default_nettype wire
